// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide engine for the multicycle MIPS execute stage.
// MULT uses radix-2 Booth; DIV uses restoring division on magnitudes with a sign fix-up.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             opdiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divby0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       state_dbg
);

  // Handshake: start is taken only in IDLE; busy stays high from the next cycle
  // through the one-cycle done pulse, and hi/lo change only on entry to DONE.
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               mprev;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   dvs;
  logic               sign_a;
  logic               sign_b;
  logic               dz;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Booth recoding of the current multiplier bit pair
  always_comb begin
    acc_next = acc;
    case ({mplier[0], mprev})
      2'b10:   acc_next = acc - mcand;
      2'b01:   acc_next = acc + mcand;
      default: acc_next = acc;
    endcase
  end

  // One extra bit on the trial subtraction tells whether the divisor fits
  assign shifted = {rem, quot[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign a_mag   = a[WIDTH-1] ? -a : a;
  assign b_mag   = b[WIDTH-1] ? -b : b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mprev  <= 1'b0;
      rem    <= '0;
      quot   <= '0;
      dvs    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          dz <= 1'b0;
          if (start) begin
            if (!opdiv) begin
              acc    <= '0;
              mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
              mplier <= b;
              mprev  <= 1'b0;
              count  <= CW'(WIDTH - 1);
              state  <= S_MULT;
            end else if (b == '0) begin
              dz    <= 1'b1;
              state <= S_DONE;
            end else begin
              quot   <= a_mag;
              dvs    <= b_mag;
              rem    <= '0;
              sign_a <= a[WIDTH-1];
              sign_b <= b[WIDTH-1];
              count  <= CW'(WIDTH - 1);
              state  <= S_DIV;
            end
          end
        end
        S_MULT: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          mprev  <= mplier[0];
          count  <= count - 1'b1;
          if (count == '0) begin
            hi    <= acc_next[2*WIDTH-1:WIDTH];
            lo    <= acc_next[WIDTH-1:0];
            state <= S_DONE;
          end
        end
        S_DIV: begin
          if (!diff[WIDTH]) begin
            rem  <= diff[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= shifted[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == '0) state <= S_FIX;
        end
        S_FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend sign
          lo    <= (sign_a ^ sign_b) ? -quot : quot;
          hi    <= sign_a ? -rem : rem;
          state <= S_DONE;
        end
        S_DONE: begin
          dz    <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign divby0    = dz;
  assign state_dbg = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: latency-level reference model with a result queue,
// per-cycle comparison of all outputs, directed literal cases and random operations.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        opdiv = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic        divby0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [2:0]  state_dbg;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(rst_n), .start(start), .opdiv(opdiv), .a(a), .b(b),
    .busy(busy), .done(done), .divby0(divby0), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: {hi, lo} computed with 64-bit signed integers
  function automatic logic [63:0] ref_res(input logic op, input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, p, q, r;
    logic [63:0] rv, qv;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    if (!op) begin
      p = sa * sb;
      return p;
    end
    q  = sa / sb;
    r  = sa % sb;
    rv = r;
    qv = q;
    return {rv[31:0], qv[31:0]};
  endfunction

  // scoreboard: {divby0, hi, lo} of each accepted operation
  logic [64:0] exp_q[$];
  int          m_left;
  logic        m_done, m_dz, m_busy, m_was_done;
  logic [31:0] m_hi, m_lo;

  task automatic retire();
    logic [64:0] e;
    e      = exp_q.pop_front();
    m_done = 1'b1;
    m_dz   = e[64];
    m_hi   = e[63:32];
    m_lo   = e[31:0];
  endtask

  initial begin
    m_left = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_busy = 0; m_was_done = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0;
        exp_q.delete();
      end else begin
        m_was_done = m_done;
        m_done = 1'b0;
        m_dz   = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) retire();
        end else if (start && !m_was_done) begin
          if (opdiv && b == 32'd0) begin
            exp_q.push_back({1'b1, m_hi, m_lo});
            retire();
          end else begin
            exp_q.push_back({1'b0, ref_res(opdiv, a, b)});
            m_left = opdiv ? 33 : 32;
          end
        end
      end
      m_busy = (m_left > 0) || m_done;
    end
  end

  // per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("divby0", divby0, m_dz);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
      end
    end
  end

  // driver
  int          lat, busy_cnt;
  bit          got_done;
  logic [31:0] r_hi, r_lo;
  logic        r_dz;

  task automatic do_op(input logic op, input logic [31:0] x, input logic [31:0] y,
                       input int intr_at, input bit again);
    start = 1'b1; opdiv = op; a = x; b = y;
    lat = 0; busy_cnt = 0; got_done = 0;
    while (!got_done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (lat == 1) begin
        a = $urandom; b = $urandom; opdiv = 1'($urandom_range(0, 1));
      end
      if (lat == intr_at) begin
        start = 1'b1; opdiv = ~op; a = $urandom; b = $urandom_range(1, 9);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got_done = 1'b1; r_hi = hi; r_lo = lo; r_dz = divby0;
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    if (again) begin
      start = 1'b1; opdiv = 1'b0; a = 32'd3; b = 32'd4;
    end
    @(negedge clk);
    start = 1'b0;
    if (again) chk("start_at_done_ignored", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_div();
    start = 1'b1; opdiv = 1'b1; a = 32'hFFFFFFF9; b = 32'd2;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_divby0", 32'(divby0), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic        op;
    logic [31:0] x, y;
    int          sel;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'd7, 32'hFFFFFFFD, 0, 0);
    chk("mult_latency", lat, 32'd33);
    chk("mult_busy_cycles", busy_cnt, 32'd33);
    chk("mult_7x-3_hi", r_hi, 32'hFFFFFFFF);
    chk("mult_7x-3_lo", r_lo, 32'hFFFFFFEB);

    do_op(1'b0, 32'h80000000, 32'h80000000, 0, 0);
    chk("mult_min_sq_hi", r_hi, 32'h40000000);
    chk("mult_min_sq_lo", r_lo, 32'h00000000);

    do_op(1'b0, 32'h12345678, 32'd0, 0, 1);
    chk("mult_zero_hi", r_hi, 32'd0);
    chk("mult_zero_lo", r_lo, 32'd0);

    do_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, 0);
    chk("div_latency", lat, 32'd34);
    chk("div_-7/2_lo", r_lo, 32'hFFFFFFFD);
    chk("div_-7/2_hi", r_hi, 32'hFFFFFFFF);

    do_op(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0);
    chk("div_7/-2_lo", r_lo, 32'hFFFFFFFD);
    chk("div_7/-2_hi", r_hi, 32'd1);

    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    chk("div_ovf_lo", r_lo, 32'h80000000);
    chk("div_ovf_hi", r_hi, 32'd0);
    chk("div_ovf_divby0", 32'(r_dz), 32'd0);

    do_op(1'b1, 32'h0ACF1234, 32'h00002000, 0, 0);
    chk("div_prior_hi", r_hi, 32'h00001234);
    chk("div_prior_lo", r_lo, 32'h00005678);

    do_op(1'b1, 32'd5, 32'd0, 0, 0);
    chk("div0_latency", lat, 32'd1);
    chk("div0_flag", 32'(r_dz), 32'd1);
    chk("div0_hi_kept", r_hi, 32'h00001234);
    chk("div0_lo_kept", r_lo, 32'h00005678);
    chk("div0_busy_after", 32'(busy), 32'd0);

    do_op(1'b0, 32'd7, 32'hFFFFFFFD, 5, 0);
    chk("intrude_hi", r_hi, 32'hFFFFFFFF);
    chk("intrude_lo", r_lo, 32'hFFFFFFEB);

    reset_mid_div();
    do_op(1'b1, 32'd100, 32'd7, 0, 0);
    chk("post_reset_lo", r_lo, 32'd14);
    chk("post_reset_hi", r_hi, 32'd2);

    for (int i = 0; i < 40; i++) begin
      op  = 1'($urandom_range(0, 1));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) y = 32'd0;
      if (sel == 1) x = 32'h80000000;
      if (sel == 2) y = 32'hFFFFFFFF;
      if (sel == 3) y = 32'd1;
      do_op(op, x, y, 0, (i % 7) == 3);
      chk("rand_latency", lat, op ? ((y == 32'd0) ? 32'd1 : 32'd34) : 32'd33);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
